// File: rtl/source_stepper.sv
// Sequential driver for the 2-bit transition stage: buffers input symbols, applies them to the
// stage one at a time, commits each result as the new state and reports it downstream.
module source_stepper #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter logic [1:0]  TARGET = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sym,
  output logic [1:0]       aa_o,
  output logic [1:0]       bb_o,
  input  logic [1:0]       cc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_state,
  output logic [CNT_W-1:0] steps,
  output logic             hit
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StEval, StOut} state_e;

  state_e           state_q, state_d;
  logic [1:0]       mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       bb_q, bb_d;
  logic [1:0]       out_state_q, out_state_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             hit_q, hit_d;

  logic full, empty, push, pop;

  assign full     = (count_q == FullCount);
  assign empty    = (count_q == '0);
  // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign in_ready = !full && !clr;
  assign push     = in_valid && in_ready;

  // FSM next-state and datapath updates; clr overrides everything at the end.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    bb_d        = bb_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
    steps_d     = steps_q;
    hit_d       = hit_q;
    pop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          bb_d    = mem_q[rd_ptr_q];
          state_d = StEval;
        end
      end
      StEval: begin
        cur_d       = cc_i;
        out_state_d = cc_i;
        out_valid_d = 1'b1;
        if (steps_q != '1) begin
          steps_d = steps_q + CNT_W'(1);
        end
        if (cc_i == TARGET) begin
          hit_d = 1'b1;
        end
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            bb_d    = mem_q[rd_ptr_q];
            state_d = StEval;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (clr) begin
      pop         = 1'b0;
      state_d     = StIdle;
      cur_d       = 2'b00;
      bb_d        = 2'b00;
      out_state_d = 2'b00;
      out_valid_d = 1'b0;
      steps_d     = '0;
      hit_d       = 1'b0;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_sym;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_q       <= 2'b00;
      bb_q        <= 2'b00;
      out_state_q <= 2'b00;
      out_valid_q <= 1'b0;
      steps_q     <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      bb_q        <= bb_d;
      out_state_q <= out_state_d;
      out_valid_q <= out_valid_d;
      steps_q     <= steps_d;
      hit_q       <= hit_d;
    end
  end

  assign aa_o      = cur_q;
  assign bb_o      = bb_q;
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign steps     = steps_q;
  assign hit       = hit_q;

endmodule
